hdr_reader: RTL and testbench

// Read-back end of the event header path. Takes header-write completions (13-bit slot address plus 4-bit error),

---
 rtl/hdr_reader.sv | 100 ++++++++++
 tb/tb_hdr_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hdr_reader.sv
// hdr_reader: fetch a 256-byte header slot over one AXI4 read burst, stream it out, then free the slot.
module hdr_reader #(
  parameter logic [18:0] BASE_ADDR = 19'h03F00,
  parameter int          NBEATS    = 32
) (
  input  logic        memclk,
  input  logic        memresetn,
  input  logic [23:0] s_cmpl_tdata,
  input  logic        s_cmpl_tvalid,
  output logic        s_cmpl_tready,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [63:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [63:0] m_hdr_tdata,
  output logic        m_hdr_tlast,
  output logic        m_hdr_tvalid,
  input  logic        m_hdr_tready,
  output logic [15:0] m_free_tdata,
  output logic        m_free_tvalid,
  input  logic        m_free_tready,
  output logic [15:0] err_count_o,
  output logic        rd_err_o
);
  localparam int CW = $clog2(NBEATS);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, FREE} state_t;
  state_t          state_q, state_d;
  logic [12:0]     slot_q, slot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            rd_err_q, rd_err_d;
  logic            last, r_hs;
  logic            unused_cmpl_bits;
  assign unused_cmpl_bits = ^{s_cmpl_tdata[23:21], s_cmpl_tdata[7:4]};
  assign m_axi_araddr  = {slot_q, BASE_ADDR};
  assign m_axi_arlen   = 8'(NBEATS - 1);
  assign m_axi_arsize  = 3'b011;
  assign m_axi_arburst = 2'b01;
  assign m_hdr_tdata   = m_axi_rdata;
  assign m_free_tdata  = {3'b0, slot_q};
  assign err_count_o   = err_cnt_q;
  assign rd_err_o      = rd_err_q;
  always_ff @(posedge memclk) begin
    if (!memresetn) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      rd_err_q  <= rd_err_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    cnt_d         = cnt_q;
    err_cnt_d     = err_cnt_q;
    rd_err_d      = rd_err_q;
    last          = cnt_q == CW'(NBEATS - 1);
    s_cmpl_tready = memresetn && state_q == IDLE && s_cmpl_tvalid;
    m_axi_arvalid = state_q == ADDR;
    m_axi_rready  = state_q == DATA && m_hdr_tready;
    m_hdr_tvalid  = state_q == DATA && m_axi_rvalid;
    m_hdr_tlast   = state_q == DATA && last;
    m_free_tvalid = state_q == FREE;
    r_hs          = m_axi_rready && m_axi_rvalid;
    case (state_q)
      IDLE: if (s_cmpl_tvalid) begin
        slot_d = s_cmpl_tdata[20:8];
        // errored writes skip the fetch but still return the slot
        if (s_cmpl_tdata[3:0] != 4'h0) begin
          state_d   = FREE;
          err_cnt_d = err_cnt_q + {15'b0, err_cnt_q != 16'hFFFF};
        end else state_d = ADDR;
      end
      ADDR: if (m_axi_arready) begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: if (r_hs) begin
        cnt_d = cnt_q + CW'(1);
        if (m_axi_rresp != 2'b00 || m_axi_rlast != last) rd_err_d = 1'b1;
        if (last) state_d = FREE;
      end
      FREE: if (m_free_tready) state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hdr_reader.sv
// tb_hdr_reader: randomized directed bench for hdr_reader with a slot/word/error reference model.
module tb_hdr_reader;
  localparam int NB = 32;
  logic        memclk = 0, memresetn = 0;
  logic [23:0] s_cmpl_tdata = '0;
  logic        s_cmpl_tvalid = 0, s_cmpl_tready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready = 0;
  logic [63:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 0, m_axi_rvalid = 0, m_axi_rready;
  logic [63:0] m_hdr_tdata;
  logic        m_hdr_tlast, m_hdr_tvalid, m_hdr_tready = 0;
  logic [15:0] m_free_tdata;
  logic        m_free_tvalid, m_free_tready = 0;
  logic [15:0] err_count_o;
  logic        rd_err_o;
  int          checks = 0, failures = 0;
  int          exp_errs = 0;
  logic        exp_rd_err = 0;

  hdr_reader dut (
    .memclk(memclk), .memresetn(memresetn),
    .s_cmpl_tdata(s_cmpl_tdata), .s_cmpl_tvalid(s_cmpl_tvalid), .s_cmpl_tready(s_cmpl_tready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_hdr_tdata(m_hdr_tdata), .m_hdr_tlast(m_hdr_tlast), .m_hdr_tvalid(m_hdr_tvalid),
    .m_hdr_tready(m_hdr_tready),
    .m_free_tdata(m_free_tdata), .m_free_tvalid(m_free_tvalid), .m_free_tready(m_free_tready),
    .err_count_o(err_count_o), .rd_err_o(rd_err_o)
  );

  always #5 memclk = ~memclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_rready"}, m_axi_rready, 0);
    chk({tag, "_hdr_tvalid"}, m_hdr_tvalid, 0);
    chk({tag, "_free_tvalid"}, m_free_tvalid, 0);
    chk({tag, "_cmpl_tready"}, s_cmpl_tready, 0);
  endtask

  task automatic header(input logic [12:0] slot, input logic [3:0] err, input int ar_wait,
                        input int free_wait, input int bad_resp, input int bad_last,
                        input int rst_beat, input logic pend, input logic [12:0] pend_slot);
    logic [63:0] words [NB];
    logic [63:0] got [$];
    int beat, budget;
    for (int i = 0; i < NB; i++) words[i] = {$urandom, $urandom};
    @(negedge memclk);
    s_cmpl_tdata  = {3'($urandom), slot, 4'($urandom), err};
    s_cmpl_tvalid = 1;
    #1 chk("cmpl_tready", s_cmpl_tready, 1);
    if (err != 0 && exp_errs < 65535) exp_errs++;
    @(negedge memclk);
    s_cmpl_tvalid = 0;
    if (err == 0) begin
      m_hdr_tready = 1;
      m_axi_rvalid = 1;
      for (int i = 0; i < ar_wait; i++) begin
        #1;
        chk("ar_hold_valid", m_axi_arvalid, 1);
        chk("ar_hold_addr", m_axi_araddr, {slot, 19'h03F00});
        chk("ar_hold_rready", m_axi_rready, 0);
        chk("ar_hold_tvalid", m_hdr_tvalid, 0);
        @(negedge memclk);
      end
      #1;
      chk("arvalid", m_axi_arvalid, 1);
      chk("araddr", m_axi_araddr, {slot, 19'h03F00});
      chk("arlen", m_axi_arlen, NB - 1);
      chk("arsize", m_axi_arsize, 3'b011);
      chk("arburst", m_axi_arburst, 2'b01);
      m_axi_arready = 1;
      @(negedge memclk);
      m_axi_arready = 0;
      beat = 0;
      budget = 0;
      while (beat < NB && budget < 2000) begin
        budget++;
        m_axi_rdata  = words[beat];
        m_axi_rresp  = beat == bad_resp ? 2'b10 : 2'b00;
        m_axi_rlast  = (beat == NB - 1) ^ (beat == bad_last);
        if (beat == rst_beat) begin
          m_axi_rvalid = 1;
          m_hdr_tready = 1;
          memresetn = 0;
          @(negedge memclk);
          #1 idle_checks("rst_mid");
          chk("rst_mid_errcnt", err_count_o, 0);
          chk("rst_mid_rderr", rd_err_o, 0);
          memresetn = 1;
          m_axi_rvalid = 0;
          m_hdr_tready = 0;
          exp_errs = 0;
          exp_rd_err = 0;
          return;
        end
        m_axi_rvalid = $urandom_range(0, 3) != 0;
        m_hdr_tready = $urandom_range(0, 1) == 1;
        #1;
        chk("hdr_tvalid", m_hdr_tvalid, m_axi_rvalid);
        chk("rready", m_axi_rready, m_hdr_tready);
        if (m_axi_rvalid) chk("tlast", m_hdr_tlast, beat == NB - 1);
        if (m_axi_rvalid && m_hdr_tready) begin
          got.push_back(m_hdr_tdata);
          if (beat == bad_resp || beat == bad_last) exp_rd_err = 1;
          beat++;
        end
        @(negedge memclk);
      end
      m_axi_rvalid = 0;
      m_hdr_tready = 0;
      m_axi_rlast  = 0;
      m_axi_rresp  = 0;
      chk("beats", beat, NB);
      chk("word_count", got.size(), NB);
      for (int i = 0; i < NB; i++) chk("word", i < got.size() ? got[i] : 64'hx, words[i]);
    end
    for (int i = 0; i <= free_wait; i++) begin
      if (pend) begin
        s_cmpl_tdata  = {3'b0, pend_slot, 8'h00};
        s_cmpl_tvalid = 1;
      end
      m_free_tready = i == free_wait;
      #1;
      chk("free_tvalid", m_free_tvalid, 1);
      chk("free_tdata", m_free_tdata, {3'b0, slot});
      chk("no_ar_in_free", m_axi_arvalid, 0);
      if (pend) chk("cmpl_blocked", s_cmpl_tready, 0);
      @(negedge memclk);
    end
    m_free_tready = 0;
    s_cmpl_tvalid = 0;
    #1;
    chk("free_done", m_free_tvalid, 0);
    chk("err_count", err_count_o, exp_errs);
    chk("rd_err", rd_err_o, exp_rd_err);
  endtask

  initial begin
    s_cmpl_tvalid = 1;
    m_axi_rvalid = 1;
    m_hdr_tready = 1;
    repeat (3) @(negedge memclk);
    #1 idle_checks("reset");
    chk("reset_errcnt", err_count_o, 0);
    chk("reset_rderr", rd_err_o, 0);
    s_cmpl_tvalid = 0;
    m_axi_rvalid = 0;
    m_hdr_tready = 0;
    memresetn = 1;
    header(13'h0005, 4'h0, 0, 0, -1, -1, -1, 0, 0);
    header(13'h1FFF, 4'h2, 0, 0, -1, -1, -1, 0, 0);
    header(13'($urandom), 4'h0, 20, 0, -1, -1, -1, 0, 0);
    header(13'($urandom), 4'h0, 1, 2, 7, -1, -1, 0, 0);
    header(13'h0001, 4'h0, 0, 10, -1, -1, -1, 1, 13'h0002);
    header(13'h0002, 4'h0, 0, 0, -1, -1, -1, 0, 0);
    header(13'h0000, 4'h0, 0, 0, -1, -1, -1, 0, 0);
    header(13'h1FFF, 4'h0, 3, 0, -1, -1, -1, 0, 0);
    header(13'($urandom), 4'h0, 0, 0, -1, -1, 12, 0, 0);
    header(13'($urandom), 4'h0, 2, 1, -1, -1, -1, 0, 0);
    header(13'($urandom), 4'h0, 0, 0, -1, 4, -1, 0, 0);
    for (int k = 0; k < 6; k++)
      header(13'($urandom), $urandom_range(0, 1) == 1 ? 4'($urandom_range(1, 15)) : 4'h0,
             $urandom_range(0, 4), $urandom_range(0, 3), -1, -1, -1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
